// File: rtl/fadd_align_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fadd_align_seq
//  Description : FP32 add/sub pre-add alignment stage. Unpacks two operands,
//                orders them by magnitude and right-aligns the smaller
//                mantissa to the larger exponent with a sticky bit, shifting
//                SHIFT_PER_CYCLE bits per cycle. Valid/ready on both sides.
//  Options     : FALIGN_EARLY_OUT_EN - saturated shifts (d>=48) skip the
//                iterative shift and complete in a single cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fadd_align_seq #(
  parameter int SHIFT_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign1,
  output logic        sign2,
  output logic [7:0]  exp_res,
  output logic [47:0] mant_big,
  output logic [47:0] mant_small,
  output logic        swapped,
  output logic        zero,
  output logic        special
);

  localparam logic [5:0] C_STEP      = 6'(SHIFT_PER_CYCLE);
  localparam logic [5:0] C_MAX_SHIFT = 6'd48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        sign1_q, sign1_d;
  logic        sign2_q, sign2_d;
  logic [7:0]  exp_res_q, exp_res_d;
  logic [47:0] mant_big_q, mant_big_d;
  logic [47:0] mant_small_q, mant_small_d;
  logic        swapped_q, swapped_d;
  logic        zero_q, zero_d;
  logic        special_q, special_d;
  logic [5:0]  rem_q, rem_d;

  // Unpacked operand fields and magnitude ordering
  logic        a_sign, b_sign;
  logic [7:0]  a_exp, b_exp, a_eff, b_eff;
  logic [47:0] a_mant, b_mant;
  logic        a_is_big;
  logic        big_sign, small_sign;
  logic [7:0]  big_exp, big_eff, small_eff;
  logic [47:0] big_mant, small_mant;
  logic [7:0]  exp_diff;
  logic [5:0]  d_sat;
  logic        is_special, is_zero;

  // Iterative shift step
  logic [5:0]  step;
  logic [47:0] lost_mask;
  logic        lost;
  logic [47:0] shifted;

  // Unpack both operands and pick the larger magnitude; ties keep A as big
  always_comb begin
    a_sign   = op_a[31];
    b_sign   = op_b[31] ^ sub;
    a_exp    = op_a[30:23];
    b_exp    = op_b[30:23];
    a_eff    = (a_exp == 8'd0) ? 8'd1 : a_exp;
    b_eff    = (b_exp == 8'd0) ? 8'd1 : b_exp;
    a_mant   = {(a_exp != 8'd0), op_a[22:0], 24'd0};
    b_mant   = {(b_exp != 8'd0), op_b[22:0], 24'd0};
    a_is_big = (op_a[30:0] >= op_b[30:0]);

    big_sign   = a_is_big ? a_sign : b_sign;
    small_sign = a_is_big ? b_sign : a_sign;
    big_exp    = a_is_big ? a_exp  : b_exp;
    big_eff    = a_is_big ? a_eff  : b_eff;
    small_eff  = a_is_big ? b_eff  : a_eff;
    big_mant   = a_is_big ? a_mant : b_mant;
    small_mant = a_is_big ? b_mant : a_mant;

    // Larger {exp,frac} implies larger effective exponent, so this never wraps
    exp_diff   = big_eff - small_eff;
    d_sat      = (exp_diff >= 8'd48) ? C_MAX_SHIFT : exp_diff[5:0];

    is_special = (a_exp == 8'hFF) || (b_exp == 8'hFF);
    is_zero    = (op_a[30:0] == 31'd0) || (op_b[30:0] == 31'd0);
  end

  // One shift step: move by min(rem, step size) and fold lost bits into bit 0
  always_comb begin
    step      = (rem_q < C_STEP) ? rem_q : C_STEP;
    lost_mask = ~({48{1'b1}} << step);
    lost      = |(mant_small_q & lost_mask);
    shifted   = (mant_small_q >> step) | {47'd0, lost};
  end

  // Next-state and datapath update; everything holds unless a branch changes it
  always_comb begin
    state_d      = state_q;
    sign1_d      = sign1_q;
    sign2_d      = sign2_q;
    exp_res_d    = exp_res_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;
    swapped_d    = swapped_q;
    zero_d       = zero_q;
    special_d    = special_q;
    rem_d        = rem_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign1_d      = big_sign;
          sign2_d      = small_sign;
          exp_res_d    = big_exp;
          mant_big_d   = big_mant;
          mant_small_d = small_mant;
          swapped_d    = ~a_is_big;
          zero_d       = is_zero;
          special_d    = is_special;
          rem_d        = d_sat;
          if (is_special || (d_sat == 6'd0)) begin
            // Specials pass through unshifted for the downstream handler
            rem_d   = 6'd0;
            state_d = ST_DONE;
          end
`ifdef FALIGN_EARLY_OUT_EN
          else if (d_sat == C_MAX_SHIFT) begin
            // Everything falls off the end: only the sticky bit survives
            mant_small_d = {47'd0, |small_mant};
            rem_d        = 6'd0;
            state_d      = ST_DONE;
          end
`endif
          else begin
            state_d = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        mant_small_d = shifted;
        rem_d        = rem_q - step;
        if (rem_q == step) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sign1_q      <= 1'b0;
      sign2_q      <= 1'b0;
      exp_res_q    <= 8'd0;
      mant_big_q   <= 48'd0;
      mant_small_q <= 48'd0;
      swapped_q    <= 1'b0;
      zero_q       <= 1'b0;
      special_q    <= 1'b0;
      rem_q        <= 6'd0;
    end else begin
      state_q      <= state_d;
      sign1_q      <= sign1_d;
      sign2_q      <= sign2_d;
      exp_res_q    <= exp_res_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
      swapped_q    <= swapped_d;
      zero_q       <= zero_d;
      special_q    <= special_d;
      rem_q        <= rem_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE) && reset_n;
  assign out_valid  = (state_q == ST_DONE);
  assign sign1      = sign1_q;
  assign sign2      = sign2_q;
  assign exp_res    = exp_res_q;
  assign mant_big   = mant_big_q;
  assign mant_small = mant_small_q;
  assign swapped    = swapped_q;
  assign zero       = zero_q;
  assign special    = special_q;

endmodule
`default_nettype wire
